sata_link_tx_framer: RTL and testbench

//  Parametrised SATA Link-layer TX frame path: appends CRC, scrambles and buffers frame dwords for the Link FSM.

---
 rtl/sata_link_pkg.sv | 44 ++++
 rtl/sata_link_sc_fifo.sv | 57 +++++
 rtl/sata_link_tx_framer.sv | 173 +++++++++++++++++
 tb/tb_sata_link_tx_framer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_link_pkg.sv
// SATA link-layer TX framer shared definitions.
// Holds the CRC/scrambler constants, their per-dword step functions and the framer state type.
package sata_link_pkg;

   localparam logic [31:0] SATA_CRC_SEED = 32'h5232_5032;
   localparam logic [31:0] SATA_CRC_POLY = 32'h04C1_1DB7;
   // LFSR holds the next 16 keystream bits, oldest in bit 0
   localparam logic [15:0] SATA_SCRAM_SEED = 16'h768D;

   typedef enum logic {
      DATA,
      CRC
   } tx_framer_state_t;

   function automatic logic [31:0] crc32_step(
      input logic [31:0] crc,
      input logic [31:0] dat
   );
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ dat[i];
         c  = {c[30:0], 1'b0} ^ (fb ? SATA_CRC_POLY : 32'h0);
      end
      return c;
   endfunction

   // returns {mask[31:0], next_lfsr[15:0]}; mask bit 0 is the first keystream bit
   function automatic logic [47:0] scram_step(
      input logic [15:0] lfsr
   );
      logic [15:0] s;
      logic [31:0] m;
      s = lfsr;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         m[i] = s[0];
         s    = {s[15] ^ s[13] ^ s[4] ^ s[0], s[15:1]};
      end
      return {m, s};
   endfunction

endpackage

// File: rtl/sata_link_sc_fifo.sv
// Generic show-ahead single-clock FIFO with fill level.
// Ports: clk, rst_n (async low), wr/wdat, rd (ignored when empty), rdat (0 when empty), empty, level.
module sata_link_sc_fifo #(
   parameter int DEPTH = 32,
   parameter int W     = 33
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr,
   input  logic [W-1:0]           wdat,
   input  logic                   rd,
   output logic [W-1:0]           rdat,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          do_rd;
   logic          full;

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);
   assign do_rd = rd & ~empty;
   assign level = cnt;
   assign rdat  = empty ? '0 : mem[rp];

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= wdat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr)    wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
         unique case ({wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n) !(wr && full)
   );

endmodule

// File: rtl/sata_link_tx_framer.sv
// SATA link TX framer: CRC append, scrambling (per-frame bypass), FIFO buffering with level/frame counts.
// Ports: tx_* payload in with tx_rdy; fifo_* show-ahead head, pop, empty/almostempty/level/frames.
// Optional SATA_LINK_TX_FRAMER_STATS_EN adds stat_frames/stat_dwords accepted counters.
module sata_link_tx_framer
   import sata_link_pkg::*;
#(
   parameter int FIFO_DEPTH   = 32,
   parameter int AE_THRESHOLD = 4,
   parameter int FRM_CNT_W    = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [31:0]                 tx_dat,
   input  logic                        tx_val,
   input  logic                        tx_eop,
   output logic                        tx_rdy,
   input  logic                        scram_bypass,
   output logic [31:0]                 fifo_data,
   output logic                        fifo_eop,
   input  logic                        fifo_rdreq,
   output logic                        fifo_empty,
   output logic                        fifo_almostempty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [FRM_CNT_W-1:0]        fifo_frames
`ifdef SATA_LINK_TX_FRAMER_STATS_EN
   ,
   output logic [15:0]                 stat_frames,
   output logic [31:0]                 stat_dwords
`endif
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = (LW > FRM_CNT_W) ? LW : FRM_CNT_W;
   localparam logic [FW-1:0] FRM_MAX = FW'((1 << FRM_CNT_W) - 1);

   tx_framer_state_t state_q, state_d;

   logic          run_q;
   logic          sop_q;
   logic          byp_q;
   logic [31:0]   crc_q;
   logic [15:0]   lfsr_q;
   logic          st_val_q, st_val_d;
   logic          st_eop_q, st_eop_d;
   logic [31:0]   st_dat_q, st_dat_d;
   logic [47:0]   scr;
   logic [31:0]   mask;
   logic [LW-1:0] used;
   logic          room1, room2;
   logic          byp_cur;
   logic          acc, crc_ld;
   logic [32:0]   head;
   logic [FW-1:0] frm_q;
   logic          wr_eop, rd_eop;

   assign scr     = scram_step(lfsr_q);
   assign mask    = scr[47:16];
   // FIFO dwords plus the one in the stage register
   assign used    = fifo_level + LW'(st_val_q);
   assign room2   = (used <= LW'(FIFO_DEPTH - 2));
   assign room1   = (used <= LW'(FIFO_DEPTH - 1));
   assign byp_cur = sop_q ? scram_bypass : byp_q;

   always_comb begin
      state_d  = state_q;
      tx_rdy   = 1'b0;
      acc      = 1'b0;
      crc_ld   = 1'b0;
      st_val_d = 1'b0;
      st_eop_d = 1'b0;
      st_dat_d = st_dat_q;
      unique case (state_q)
         DATA: begin
            // one slot always held back for the CRC dword
            tx_rdy = run_q & room2;
            acc    = tx_rdy & tx_val;
            if (acc) begin
               st_val_d = 1'b1;
               st_dat_d = tx_dat ^ (byp_cur ? 32'h0 : mask);
               if (tx_eop) state_d = CRC;
            end
         end
         CRC: begin
            if (room1) begin
               crc_ld   = 1'b1;
               st_val_d = 1'b1;
               st_eop_d = 1'b1;
               st_dat_d = crc_q ^ (byp_q ? 32'h0 : mask);
               state_d  = DATA;
            end
         end
         default: state_d = DATA;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= DATA;
         run_q    <= 1'b0;
         sop_q    <= 1'b1;
         byp_q    <= 1'b0;
         crc_q    <= SATA_CRC_SEED;
         lfsr_q   <= SATA_SCRAM_SEED;
         st_val_q <= 1'b0;
         st_eop_q <= 1'b0;
         st_dat_q <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         st_val_q <= st_val_d;
         st_eop_q <= st_eop_d;
         st_dat_q <= st_dat_d;
         if (acc) begin
            crc_q  <= crc32_step(crc_q, tx_dat);
            lfsr_q <= scr[15:0];
            sop_q  <= 1'b0;
            if (sop_q) byp_q <= scram_bypass;
         end
         if (crc_ld) begin
            crc_q  <= SATA_CRC_SEED;
            lfsr_q <= SATA_SCRAM_SEED;
            sop_q  <= 1'b1;
         end
      end
   end

   sata_link_sc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (33)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .wr    (st_val_q),
      .wdat  ({st_eop_q, st_dat_q}),
      .rd    (fifo_rdreq),
      .rdat  (head),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign {fifo_eop, fifo_data} = head;
   assign fifo_almostempty      = (fifo_level <= LW'(AE_THRESHOLD));

   assign wr_eop = st_val_q & st_eop_q;
   assign rd_eop = fifo_rdreq & ~fifo_empty & fifo_eop;

   // exact count kept wide; the port view saturates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frm_q <= '0;
      end else if (wr_eop && !rd_eop) begin
         frm_q <= frm_q + 1'b1;
      end else if (rd_eop && !wr_eop) begin
         frm_q <= frm_q - 1'b1;
      end
   end

   assign fifo_frames = (frm_q > FRM_MAX) ? {FRM_CNT_W{1'b1}}
                                          : frm_q[FRM_CNT_W-1:0];

`ifdef SATA_LINK_TX_FRAMER_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_frames <= '0;
         stat_dwords <= '0;
      end else if (acc) begin
         stat_dwords <= stat_dwords + 1'b1;
         if (tx_eop) stat_frames <= stat_frames + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sata_link_tx_framer.sv
// Scoreboard bench for sata_link_tx_framer (FIFO_DEPTH=8, AE_THRESHOLD=4, FRM_CNT_W=2).
// Stimulus pushes expected FIFO dwords; a monitor pops and compares them.
module tb_sata_link_tx_framer;

   localparam logic [31:0] SEED = 32'h5232_5032;
   localparam logic [31:0] POLY = 32'h04C1_1DB7;
   localparam logic [31:0] KS0  = 32'hC2D2_768D;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] tx_dat = '0;
   logic        tx_val = 1'b0;
   logic        tx_eop = 1'b0;
   logic        tx_rdy;
   logic        scram_bypass = 1'b0;
   logic [31:0] fifo_data;
   logic        fifo_eop;
   logic        fifo_rdreq = 1'b0;
   logic        fifo_empty;
   logic        fifo_almostempty;
   logic [3:0]  fifo_level;
   logic [1:0]  fifo_frames;
`ifdef SATA_LINK_TX_FRAMER_STATS_EN
   logic [15:0] stat_frames;
   logic [31:0] stat_dwords;
`endif

   int          n_chk = 0;
   int          n_fail = 0;
   logic [32:0] exp_q[$];
   bit          ks[0:511];
   logic [31:0] m_crc = SEED;
   int          m_idx = 0;
   bit          m_byp = 1'b0;
   bit          m_sop = 1'b1;
   int          pop_left = 0;
   int          w;

   sata_link_tx_framer #(
      .FIFO_DEPTH   (8),
      .AE_THRESHOLD (4),
      .FRM_CNT_W    (2)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .tx_dat           (tx_dat),
      .tx_val           (tx_val),
      .tx_eop           (tx_eop),
      .tx_rdy           (tx_rdy),
      .scram_bypass     (scram_bypass),
      .fifo_data        (fifo_data),
      .fifo_eop         (fifo_eop),
      .fifo_rdreq       (fifo_rdreq),
      .fifo_empty       (fifo_empty),
      .fifo_almostempty (fifo_almostempty),
      .fifo_level       (fifo_level),
      .fifo_frames      (fifo_frames)
`ifdef SATA_LINK_TX_FRAMER_STATS_EN
      ,
      .stat_frames      (stat_frames),
      .stat_dwords      (stat_dwords)
`endif
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ksm(input int k);
      logic [31:0] m;
      for (int b = 0; b < 32; b++) m[b] = ks[32*k + b];
      return m;
   endfunction

   function automatic logic [31:0] crc_ref(input logic [31:0] c,
                                           input logic [31:0] d);
      logic [31:0] r;
      r = c ^ d;
      for (int i = 0; i < 32; i++)
         r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      return r;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_crc = SEED;
      m_idx = 0;
      m_sop = 1'b1;
   endtask

   task automatic send(input logic [31:0] d, input bit eop, input bit byp,
                       output int waited);
      @(negedge clk);
      tx_dat = d;
      tx_eop = eop;
      tx_val = 1'b1;
      scram_bypass = byp;
      waited = 0;
      while (!tx_rdy && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!tx_rdy) begin
         n_chk++;
         n_fail++;
         $display("FAIL send timeout: tx_rdy stuck 0 for dword %h", d);
         tx_val = 1'b0;
      end else begin
         if (m_sop) m_byp = byp;
         exp_q.push_back({1'b0, m_byp ? d : (d ^ ksm(m_idx))});
         m_crc = crc_ref(m_crc, d);
         m_idx++;
         m_sop = 1'b0;
         if (eop) begin
            exp_q.push_back({1'b1, m_byp ? m_crc : (m_crc ^ ksm(m_idx))});
            m_crc = SEED;
            m_idx = 0;
            m_sop = 1'b1;
         end
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      tx_val = 1'b0;
      tx_eop = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !fifo_empty) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain queue", exp_q.size(), 0);
      chk("drain empty", fifo_empty, 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " tx_rdy"}, tx_rdy, 0);
      chk({tag, " empty"}, fifo_empty, 1);
      chk({tag, " almostempty"}, fifo_almostempty, 1);
      chk({tag, " level"}, fifo_level, 0);
      chk({tag, " frames"}, fifo_frames, 0);
      chk({tag, " data"}, fifo_data, 0);
      chk({tag, " eop"}, fifo_eop, 0);
   endtask

   // monitor: pops and compares whenever the FIFO presents a dword
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         fifo_rdreq = 1'b0;
         if (reset_n && pop_left != 0 && !fifo_empty) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected dword: got %h eop %b", fifo_data,
                        fifo_eop);
            end else begin
               e = exp_q.pop_front();
               chk("fifo dword", {fifo_eop, fifo_data}, e);
            end
            fifo_rdreq = 1'b1;
            if (pop_left > 0) pop_left--;
         end
      end
   end

   initial begin
      logic [31:0] k0;
      k0 = KS0;
      for (int b = 0; b < 32; b++) ks[b] = k0[b];
      for (int n = 32; n < 512; n++)
         ks[n] = ks[n-1] ^ ks[n-3] ^ ks[n-12] ^ ks[n-16];

      // reset state and release
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      reset_n = 1'b1;
      chk("rdy before first edge", tx_rdy, 0);
      @(posedge clk);
      #1;
      chk("rdy after first edge", tx_rdy, 1);

      // 1: zero frame, scrambled
      pop_left = -1;
      send(32'h0, 0, 0, w);
      send(32'h0, 0, 0, w);
      send(32'h0, 1, 0, w);
      idle();
      drain();
      chk("t1 frames", fifo_frames, 0);

      // 2: zero frame, bypassed; frame count 0 -> 1 -> 0
      pop_left = 0;
      send(32'h0, 0, 1, w);
      send(32'h0, 0, 1, w);
      send(32'h0, 1, 1, w);
      idle();
      repeat (3) @(negedge clk);
      chk("t2 frames buffered", fifo_frames, 1);
      chk("t2 level", fifo_level, 4);
      pop_left = -1;
      drain();
      chk("t2 frames popped", fifo_frames, 0);

      // 3: fill without pops
      pop_left = 0;
      for (int i = 1; i <= 7; i++) begin
         send(32'h1000_0000 + i, 0, 0, w);
         #1;
         chk("t3 level", fifo_level, i - 1);
         chk("t3 almostempty", fifo_almostempty, (i - 1) <= 4);
      end
      @(negedge clk);
      tx_dat = 32'h1000_0008;
      tx_val = 1'b1;
      chk("t3 rdy at 7", tx_rdy, 0);
      @(negedge clk);
      chk("t3 level full-1", fifo_level, 7);
      chk("t3 rdy held", tx_rdy, 0);
      chk("t3 almostempty off", fifo_almostempty, 0);
      pop_left = -1;
      send(32'h1000_0008, 1, 0, w);
      idle();
      drain();

      // 4a: frame counter saturation
      pop_left = 0;
      for (int k = 0; k < 4; k++) send(32'hA5A5_0000 + k, 1, k[0], w);
      idle();
      repeat (3) @(negedge clk);
      chk("t4 level full", fifo_level, 8);
      chk("t4 frames sat", fifo_frames, 3);
      chk("t4 rdy full", tx_rdy, 0);
      pop_left = 2;
      repeat (4) @(negedge clk);
      chk("t4 frames hidden 3", fifo_frames, 3);
      pop_left = 2;
      repeat (4) @(negedge clk);
      chk("t4 frames 2", fifo_frames, 2);
      pop_left = -1;
      drain();

      // 4b: back-to-back single-dword frames with pops
      for (int k = 0; k < 6; k++) begin
         send(32'hB000_0000 + (k * 32'h0101_0101), 1, 0, w);
         #1;
         if (k >= 1) begin
            chk("t4 rdy low cycles", w, 1);
            chk("t4 level stable", fifo_level, 1);
         end
      end
      idle();
      drain();

      // 5: reset mid-frame
      pop_left = 0;
      send(32'hDEAD_0001, 0, 0, w);
      send(32'hDEAD_0002, 0, 0, w);
      @(negedge clk);
      reset_n = 1'b0;
      tx_val = 1'b0;
      tx_eop = 1'b0;
      #1;
      chk_reset_outs("midreset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      send(32'h1234_5678, 0, 0, w);
      idle();
      @(negedge clk);
      chk("t5 first after reset", fifo_data, 32'h1234_5678 ^ KS0);
      pop_left = -1;
      send(32'h9ABC_DEF0, 0, 0, w);
      send(32'h0F0F_0F0F, 1, 0, w);
      idle();
      drain();

      // 6: 10 frames of 7 dwords from a clean reset
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int f = 0; f < 10; f++)
         for (int j = 0; j < 7; j++)
            send(32'hC000_0000 + (f << 8) + j, j == 6, f[0], w);
      idle();
      drain();
`ifdef SATA_LINK_TX_FRAMER_STATS_EN
      chk("stat_frames", stat_frames, 10);
      chk("stat_dwords", stat_dwords, 70);
`endif

      chk("end frames", fifo_frames, 0);
      chk("end level", fifo_level, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
